// File: rtl/booth_pkg.sv
// Shared constants, state/operation encodings and the Booth pair decoder
// for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH = 32;
  localparam int BOOTH_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_e;

  // {Q[0], q_-1}: 01 -> add M, 10 -> subtract M, 00/11 -> nothing.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand and product valid/ready channels of the Booth multiplier.
interface booth_seq_ctrl_if import booth_pkg::*; #(
  parameter int WIDTH = BOOTH_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_step.sv
// One combinational Booth phase: conditional add/sub of the sign-extended
// multiplicand into A, then arithmetic right shift of {A, Q, q_-1}.
module booth_step import booth_pkg::*; #(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_m1_o,
  output booth_op_e        op_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  assign m_ext = {m_i[WIDTH-1], m_i};

  always_comb begin
    op_o = booth_decode(q_i[0], q_m1_i);
    case (op_o)
      ADD:     sum = a_i + m_ext;
      SUB:     sum = a_i - m_ext;
      default: sum = a_i;
    endcase
    a_o    = {sum[WIDTH], sum[WIDTH:1]};
    q_o    = {sum[0], q_i[WIDTH-1:1]};
    q_m1_o = q_i[0];
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller: accepts an operand pair, runs WIDTH Booth phases
// (one per clock) and presents the signed product on the output channel.
module booth_seq_ctrl import booth_pkg::*; #(
  parameter int WIDTH = BOOTH_WIDTH,
  parameter int CNT_W = BOOTH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  booth_seq_ctrl_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [WIDTH-1:0] add_en,
  output logic [WIDTH-1:0] sub_en
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   add_q, add_d;
  logic [WIDTH-1:0]   sub_q, sub_d;

  logic [WIDTH:0]     step_a;
  logic [WIDTH-1:0]   step_q;
  logic               step_q_m1;
  booth_op_e          step_op;
  logic               accept;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .a_o    (step_a),
    .q_o    (step_q),
    .q_m1_o (step_q_m1),
    .op_o   (step_op)
  );

  // Ready is withheld under flush so an offered operand pair is never dropped.
  assign bus.in_ready  = !rst && !flush &&
                         (state_q == IDLE || (state_q == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = prod_q;
  assign busy          = (state_q == RUN);
  assign phase_cnt     = cnt_q;
  assign add_en        = add_q;
  assign sub_en        = sub_q;

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path
    // through the decode below can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q_m1_d  = q_m1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    add_d   = add_q;
    sub_d   = sub_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (state_q == RUN) begin
        a_d    = step_a;
        q_d    = step_q;
        q_m1_d = step_q_m1;
        if (step_op == ADD) add_d[cnt_q[IDX_W-1:0]] = 1'b1;
        if (step_op == SUB) sub_d[cnt_q[IDX_W-1:0]] = 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          prod_d  = {step_a[WIDTH-1:0], step_q};
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (state_q == DONE && bus.out_ready) begin
        state_d = IDLE;
      end

      // Covers both the IDLE accept and the back-to-back accept from DONE.
      if (accept) begin
        m_d     = bus.multiplicand;
        q_d     = bus.multiplier;
        a_d     = '0;
        q_m1_d  = 1'b0;
        cnt_d   = '0;
        add_d   = '0;
        sub_d   = '0;
        state_d = RUN;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      add_q   <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      add_q   <= add_d;
      sub_q   <= sub_d;
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and randomized checks of the sequential Booth multiplier against
// hand-computed products and a signed-multiply reference.
module tb_booth_seq_ctrl;
  import booth_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        busy;
  logic [5:0]  phase_cnt;
  logic [W-1:0] add_en, sub_en;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  booth_seq_ctrl_if #(.WIDTH(W)) bus ();

  booth_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .phase_cnt (phase_cnt),
    .add_en    (add_en),
    .sub_en    (sub_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && !flush && bus.out_valid && bus.out_ready) xfers++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair and return one cycle after the accept edge.
  task automatic send(input logic [W-1:0] m, input logic [W-1:0] q);
    int n = 0;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.in_valid     = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("send_timeout", 64'(n), 64'(0));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until out_valid is seen.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 64'(n), 64'(0));
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic mul(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                     input logic [63:0] exp);
    int n;
    send(m, q);
    wait_out(tag, n);
    check({tag, "_prod"}, bus.product, exp);
    take();
  endtask

  initial begin
    int n;
    int hits;
    int base;
    logic [63:0] held;
    logic [W-1:0] rm, rq;
    longint rexp;

    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b1;

    // Reset state while rst is held.
    tick();
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_busy",      64'(busy),          64'(0));
    check("rst_phase",     64'(phase_cnt),     64'(0));
    check("rst_product",   bus.product,        64'(0));
    check("rst_add_sub",   {add_en, sub_en},   64'(0));
    rst = 1'b0;
    tick();
    check("idle_in_ready", 64'(bus.in_ready), 64'(1));

    // 3*5 with latency: Q=101b -> sub at phases 0,2 and add at 1,3.
    send(32'd3, 32'd5);
    check("run_busy", 64'(busy), 64'(1));
    check("run_in_ready", 64'(bus.in_ready), 64'(0));
    wait_out("m3q5", n);
    check("m3q5_latency", 64'(n), 64'(32));
    check("m3q5_prod", bus.product, 64'h0000_0000_0000_000F);
    check("m3q5_sub_en", 64'(sub_en), 64'h5);
    check("m3q5_add_en", 64'(add_en), 64'hA);
    take();
    check("m3q5_no_dup", 64'(bus.out_valid), 64'(0));

    mul("m6q3", 32'd6, 32'd3, 64'd18);
    check("m6q3_sub_en_held", 64'(sub_en), 64'h1);
    check("m6q3_add_en_held", 64'(add_en), 64'h4);

    mul("m-7q6",  32'hFFFF_FFF9, 32'd6,        64'hFFFF_FFFF_FFFF_FFD6);
    mul("mminsq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    mul("mminq1", 32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000);
    check("mminq1_sub_en", 64'(sub_en), 64'h1);
    check("mminq1_add_en", 64'(add_en), 64'h2);

    // Backpressure: 100 * -3 = -300 held for 10 cycles, then back-to-back 2*2.
    bus.out_ready = 1'b0;
    send(32'd100, 32'hFFFF_FFFD);
    wait_out("bp", n);
    held = bus.product;
    check("bp_prod", held, 64'hFFFF_FFFF_FFFF_FED4);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.product !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) hits++;
    end
    check("bp_stable_cycles_bad", 64'(hits), 64'(0));
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd2;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    #1;
    check("b2b_in_ready", 64'(bus.in_ready), 64'(1));
    base = xfers;
    tick();
    bus.in_valid = 1'b0;
    check("b2b_xfer", 64'(xfers - base), 64'(1));
    check("b2b_busy", 64'(busy), 64'(1));
    check("b2b_out_valid_low", 64'(bus.out_valid), 64'(0));
    wait_out("b2b", n);
    check("b2b_latency", 64'(n), 64'(32));
    check("b2b_prod", bus.product, 64'd4);
    take();

    // Asynchronous reset mid-run at phase 15.
    send(32'd6, 32'd3);
    repeat (15) tick();
    check("rstmid_phase", 64'(phase_cnt), 64'(15));
    rst = 1'b1;
    #1;
    check("rstmid_busy",      64'(busy),          64'(0));
    check("rstmid_phase0",    64'(phase_cnt),     64'(0));
    check("rstmid_product",   bus.product,        64'(0));
    check("rstmid_add_sub",   {add_en, sub_en},   64'(0));
    check("rstmid_out_valid", 64'(bus.out_valid), 64'(0));
    check("rstmid_in_ready",  64'(bus.in_ready),  64'(0));
    #2;
    rst = 1'b0;
    tick();

    // Flush mid-run at phase 15: partial history kept, no output, then -1*-1.
    send(32'd6, 32'd3);
    repeat (15) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy",  64'(busy),      64'(0));
    check("flush_phase", 64'(phase_cnt), 64'(0));
    check("flush_add_en_kept", 64'(add_en), 64'h4);
    check("flush_sub_en_kept", 64'(sub_en), 64'h1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) hits++;
      tick();
    end
    check("flush_no_out_valid", 64'(hits), 64'(0));
    mul("m-1q-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // Random signed pairs with random output backpressure gaps.
    base = xfers;
    for (int i = 0; i < 1000; i++) begin
      rm = $urandom();
      rq = $urandom();
      if (i == 0) rm = 32'h7FFF_FFFF;
      if (i == 1) rq = 32'h8000_0000;
      rexp = longint'($signed(rm)) * longint'($signed(rq));
      bus.out_ready = 1'b0;
      send(rm, rq);
      wait_out("rand", n);
      repeat ($urandom_range(0, 3)) tick();
      check("rand_prod", bus.product, rexp);
      take();
    end
    check("rand_xfer_count", 64'(xfers - base), 64'(1000));
    check("rand_end_idle", 64'(bus.out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
